// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search blocks: plaintext character bounds,
// default message length and the key-search checker state encoding.
package rc4_pkg;

    localparam int unsigned MSG_LEN_DEFAULT = 32;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    typedef enum logic [2:0] {
        KS_IDLE,
        KS_ADDR,
        KS_WAIT,
        KS_CHECK,
        KS_NEXT_KEY,
        KS_FOUND,
        KS_EXHAUSTED
    } ks_state_e;

endpackage

// File: rtl/rc4_char_validator.sv
// Combinational plaintext filter: accepts a space or a lowercase letter a..z.
module rc4_char_validator
    import rc4_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       valid_o
);

    always_comb begin
        valid_o = (char_i == CHAR_SPACE) || ((char_i >= CHAR_LO) && (char_i <= CHAR_HI));
    end

endmodule

// File: rtl/rc4_key_search_checker.sv
// Scans the decrypted message in d-RAM after each decrypt pass; either declares the
// current key found or advances the key and asks the decrypt FSM to run again.
module rc4_key_search_checker
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN   = MSG_LEN_DEFAULT,
    parameter int unsigned KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX = {2'b00, {(KEY_WIDTH-2){1'b1}}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [7:0]           dram_addr,
    input  logic [7:0]           dram_q,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 restart,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [7:0]           fail_index
);

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    ks_state_e            state_q;
    logic [7:0]           idx_q;
    logic [7:0]           dram_addr_q;
    logic [KEY_WIDTH-1:0] key_q;
    logic                 restart_q;
    logic                 busy_q;
    logic                 found_q;
    logic                 exhausted_q;
    logic [7:0]           fail_index_q;
    logic                 byte_ok;

    rc4_char_validator u_validator (
        .char_i  (dram_q),
        .valid_o (byte_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= KS_IDLE;
            idx_q        <= '0;
            dram_addr_q  <= '0;
            key_q        <= '0;
            restart_q    <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            fail_index_q <= '0;
        end else begin
            restart_q <= 1'b0;
            case (state_q)
                KS_IDLE: begin
                    if (start) begin
                        state_q     <= KS_ADDR;
                        idx_q       <= '0;
                        dram_addr_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                KS_ADDR:  state_q <= KS_WAIT;
                // RAM has latched the address during WAIT, so q is valid in CHECK
                KS_WAIT:  state_q <= KS_CHECK;
                KS_CHECK: begin
                    if (byte_ok) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= KS_FOUND;
                            found_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= KS_ADDR;
                            idx_q       <= idx_q + 8'd1;
                            dram_addr_q <= idx_q + 8'd1;
                        end
                    end else begin
                        fail_index_q <= idx_q;
                        busy_q       <= 1'b0;
                        if (key_q == KEY_MAX) begin
                            state_q     <= KS_EXHAUSTED;
                            exhausted_q <= 1'b1;
                        end else begin
                            state_q <= KS_NEXT_KEY;
                        end
                    end
                end
                KS_NEXT_KEY: begin
                    key_q     <= key_q + 1'b1;
                    restart_q <= 1'b1;
                    state_q   <= KS_IDLE;
                end
                KS_FOUND:     state_q <= KS_FOUND;
                KS_EXHAUSTED: state_q <= KS_EXHAUSTED;
                default:      state_q <= KS_IDLE;
            endcase
        end
    end

    assign dram_addr  = dram_addr_q;
    assign secret_key = key_q;
    assign restart    = restart_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign exhausted  = exhausted_q;
    assign fail_index = fail_index_q;

endmodule
